// File: rtl/apple_video_timing_counter.sv
`default_nettype none
// ============================================================================
// Module   : apple_video_timing_counter
// Brief    : Apple II H/V video timing chain with blank, sync, burst and
//            line/frame pulses. Define APPLE_VIDEO_PAL_EN for a 312-line frame.
// Revision : 1.0 - initial release
// ============================================================================
module apple_video_timing_counter #(
    parameter logic [6:0] H_RELOAD      = 7'h40,
    parameter logic [8:0] V_RELOAD_NTSC = 9'h0FA,
    parameter logic [8:0] V_RELOAD_PAL  = 9'h0C8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CE,
    output logic [6:0] H,
    output logic [8:0] V,
    output logic       HBL,
    output logic       VBL,
    output logic       BLANK,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       CBURST,
    output logic       LINE_END,
    output logic       FRAME_END
);

`ifdef APPLE_VIDEO_PAL_EN
    localparam bit C_PAL = 1'b1;
`else
    localparam bit C_PAL = 1'b0;
`endif

    localparam logic [8:0] C_V_RELOAD = C_PAL ? V_RELOAD_PAL : V_RELOAD_NTSC;

    logic [6:0] r_h;
    logic [8:0] r_v;
    logic [6:0] w_h_next;
    logic [8:0] w_v_next;
    logic       w_h_last;
    logic       w_v_last;

    assign w_h_last = (r_h == 7'h7F);
    assign w_v_last = (r_v == 9'h1FF);

    // 0x00 is the long HPE' state; 0x7F wraps naturally to 0x00, and any
    // stray value in 0x01..0x3F just counts up into 0x40.
    always_comb begin
        w_h_next = r_h + 7'd1;
        if (r_h == 7'h00) begin
            w_h_next = H_RELOAD;
        end
        w_v_next = r_v;
        if (w_h_last) begin
            w_v_next = w_v_last ? C_V_RELOAD : (r_v + 9'd1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_h <= 7'h00;
            r_v <= C_V_RELOAD;
        end else if (CE) begin
            r_h <= w_h_next;
            r_v <= w_v_next;
        end
    end

    assign H         = r_h;
    assign V         = r_v;
    assign HBL       = ~r_h[6] | (r_h[5:3] < 3'd3);
    assign VBL       = r_v[7] & r_v[6];
    assign BLANK     = HBL | VBL;
    assign HSYNC     = (r_h[6:2] == 5'b10010);
    assign CBURST    = (r_h[6:2] == 5'b10011) & ~VBL;
    assign VSYNC     = (r_v[8:2] == 7'h78);
    assign LINE_END  = CE & w_h_last;
    assign FRAME_END = LINE_END & w_v_last;

endmodule
`default_nettype wire

// File: tb/tb_apple_video_timing_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apple_video_timing_counter
// Brief    : Self-checking bench: vector table, random CE against a line/pixel
//            position model, and hand-written reset, line and frame sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apple_video_timing_counter;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       CE = 1'b0;
    logic [6:0] H;
    logic [8:0] V;
    logic       HBL, VBL, BLANK, HSYNC, VSYNC, CBURST, LINE_END, FRAME_END;

`ifdef APPLE_VIDEO_PAL_EN
    localparam int V_RL = 'h0C8;
    localparam int FRAME_CES = 20280;
    localparam int FRAME_LINES = 312;
`else
    localparam int V_RL = 'h0FA;
    localparam int FRAME_CES = 17030;
    localparam int FRAME_LINES = 262;
`endif

    apple_video_timing_counter dut (
        .CLK(CLK), .RESET(RESET), .CE(CE), .H(H), .V(V),
        .HBL(HBL), .VBL(VBL), .BLANK(BLANK), .HSYNC(HSYNC), .VSYNC(VSYNC),
        .CBURST(CBURST), .LINE_END(LINE_END), .FRAME_END(FRAME_END)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;

    // Model: pos is the slot within the 65-state line, line counts from the
    // reload value up to 0x1FF.
    int pos = 0;
    int line = 0;

    logic le_s, fe_s, vbl_s, vsync_s;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int eh, ev;
        bit ehbl, evbl, ele;
        eh   = (pos == 0) ? 0 : 'h3F + pos;
        ev   = V_RL + line;
        ehbl = (eh < 'h58);
        evbl = !(ev >= 'h100 && ev < 'h1C0);
        ele  = CE && (pos == 64);
        chk("H", int'(H), eh);
        chk("V", int'(V), ev);
        chk("HBL", int'(HBL), int'(ehbl));
        chk("VBL", int'(VBL), int'(evbl));
        chk("BLANK", int'(BLANK), int'(ehbl || evbl));
        chk("HSYNC", int'(HSYNC), int'(eh >= 'h48 && eh <= 'h4B));
        chk("CBURST", int'(CBURST), int'(eh >= 'h4C && eh <= 'h4F && !evbl));
        chk("VSYNC", int'(VSYNC), int'(ev >= 'h1E0 && ev <= 'h1E3));
        chk("LINE_END", int'(LINE_END), int'(ele));
        chk("FRAME_END", int'(FRAME_END), int'(ele && ev == 'h1FF));
    endtask

    task automatic cyc(input logic ce);
        @(negedge CLK);
        CE = ce;
        #1;
        check_model();
        le_s = LINE_END; fe_s = FRAME_END; vbl_s = VBL; vsync_s = VSYNC;
        @(posedge CLK);
        if (ce) begin
            if (pos == 64) line = (line + 1) % FRAME_LINES;
            pos = (pos + 1) % 65;
        end
    endtask

    typedef struct {
        logic rst;
        logic ce;
        int   h;
        int   hbl;
        int   le;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int ce_cnt, le_cnt, lines, disp, vs_lines, guard;
        bit found;

        vecs[0] = '{1'b1, 1'b1, 'h00, 1, 0};
        vecs[1] = '{1'b0, 1'b0, 'h00, 1, 0};
        vecs[2] = '{1'b0, 1'b1, 'h40, 1, 0};
        vecs[3] = '{1'b0, 1'b1, 'h41, 1, 0};
        vecs[4] = '{1'b0, 1'b0, 'h41, 1, 0};
        vecs[5] = '{1'b1, 1'b1, 'h00, 1, 0};
        vecs[6] = '{1'b0, 1'b1, 'h40, 1, 0};

        repeat (2) @(posedge CLK);
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            RESET = vecs[i].rst;
            CE    = vecs[i].ce;
            @(posedge CLK);
            #1;
            chk($sformatf("vec%0d_H", i), int'(H), vecs[i].h);
            chk($sformatf("vec%0d_V", i), int'(V), V_RL);
            chk($sformatf("vec%0d_HBL", i), int'(HBL), vecs[i].hbl);
            chk($sformatf("vec%0d_VBL", i), int'(VBL), 1);
            chk($sformatf("vec%0d_LE", i), int'(LINE_END), vecs[i].le);
        end
        pos = 1; line = 0;

        // Random enable pattern against the model.
        for (int i = 0; i < 3000; i++) cyc($urandom_range(0, 3) == 0);

        // Asynchronous reset between edges with CE high.
        @(negedge CLK);
        CE = 1'b1;
        #2 RESET = 1'b1;
        #1;
        chk("arst_H", int'(H), 0);
        chk("arst_V", int'(V), V_RL);
        chk("arst_blank", int'({HBL, VBL, BLANK}), 3'b111);
        chk("arst_pulses", int'({HSYNC, VSYNC, CBURST, LINE_END, FRAME_END}), 0);
        @(posedge CLK);
        #1;
        chk("arst_hold_H", int'(H), 0);
        @(negedge CLK);
        RESET = 1'b0;
        CE = 1'b0;
        pos = 0; line = 0;

        // CE on every 14th clock for one whole line.
        ce_cnt = 0; le_cnt = 0;
        for (int k = 0; k < 65 * 14; k++) begin
            cyc(k % 14 == 0);
            if (k % 14 == 0) ce_cnt++;
            if (le_s) le_cnt++;
        end
        #1;
        chk("line_ce_count", ce_cnt, 65);
        chk("line_end_count", le_cnt, 1);
        chk("line_wrap_H", int'(H), 0);
        chk("line_wrap_V", int'(V), V_RL + 1);

        repeat (50) cyc(1'b0);

        // Full frame with CE held high.
        found = 0; guard = 0;
        while (!found && guard < FRAME_CES + 100) begin
            cyc(1'b1);
            guard++;
            found = fe_s;
        end
        chk("frame_first_found", int'(found), 1);
        #1;
        chk("wrap_H", int'(H), 0);
        chk("wrap_V", int'(V), V_RL);

        ce_cnt = 0; lines = 0; disp = 0; vs_lines = 0; found = 0;
        while (!found && ce_cnt < FRAME_CES + 100) begin
            cyc(1'b1);
            ce_cnt++;
            if (le_s) begin
                lines++;
                if (!vbl_s) disp++;
                if (vsync_s) vs_lines++;
            end
            found = fe_s;
        end
        #1;
        chk("frame_second_found", int'(found), 1);
        chk("frame_ce_count", ce_cnt, FRAME_CES);
        chk("frame_line_count", lines, FRAME_LINES);
        chk("frame_display_lines", disp, 192);
        chk("frame_vsync_lines", vs_lines, 4);
        chk("wrap2_H", int'(H), 0);
        chk("wrap2_V", int'(V), V_RL);
        cyc(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
